// File: rtl/draw_triangle_stream_if.sv
// Command, vertex and pixel-stream bundle between the draw command decoder,
// the triangle rasteriser (slave) and the framebuffer write port.
interface draw_triangle_stream_if #(
  parameter int COORD_W = 8
);
  logic               start;
  logic               abort;
  logic [COORD_W-1:0] X_0;
  logic [COORD_W-1:0] Y_0;
  logic [COORD_W-1:0] X_1;
  logic [COORD_W-1:0] Y_1;
  logic [COORD_W-1:0] X_2;
  logic [COORD_W-1:0] Y_2;
  logic [COORD_W-1:0] X_Out;
  logic [COORD_W-1:0] Y_Out;
  logic               pix_valid;
  logic               pix_ready;
  logic [1:0]         edge_idx;
  logic               busy;
  logic               finish;

  modport master (
    output start, abort, X_0, Y_0, X_1, Y_1, X_2, Y_2, pix_ready,
    input  X_Out, Y_Out, pix_valid, edge_idx, busy, finish
  );

  modport slave (
    input  start, abort, X_0, Y_0, X_1, Y_1, X_2, Y_2, pix_ready,
    output X_Out, Y_Out, pix_valid, edge_idx, busy, finish
  );
endinterface

// File: rtl/draw_triangle_stream.sv
// Triangle-outline rasteriser: Bresenham over V0->V1, V1->V2, V2->V0, one pixel per cycle.
// Optional macro SKIP_SHARED_VERTEX_EN drops each edge's final endpoint so every vertex is emitted once.
module draw_triangle_stream #(
  parameter int COORD_W = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  draw_triangle_stream_if.slave bus_if
);
  localparam int SW = COORD_W + 2;
  localparam int EW = COORD_W + 3;
  localparam logic [COORD_W-1:0] C_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t               state_q;
  logic [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [1:0]           edge_q;
  logic                 valid_q, busy_q, finish_q;
  logic signed [SW-1:0] dx_q, dy_q, err_q;
  logic                 sx_neg_q, sy_neg_q;

  logic [COORD_W-1:0]   xa_s, ya_s, xb_s, yb_s;
  logic signed [SW-1:0] ddx_s, ddy_s, adx_s, ndy_s, err_nxt_s;
  logic signed [EW-1:0] e2_s, dx_ext_s, dy_ext_s;
  logic                 step_x_s, step_y_s, edge_last_s;
  logic [COORD_W-1:0]   x_nxt_s, y_nxt_s;
`ifdef SKIP_SHARED_VERTEX_EN
  logic                 zero_len_s, all_same_s;
`endif

  // Select start (a) and end (b) vertex of the current edge
  always_comb begin
    xa_s = x0_q;
    ya_s = y0_q;
    xb_s = x1_q;
    yb_s = y1_q;
    case (edge_q)
      2'd0: begin
        xa_s = x0_q; ya_s = y0_q; xb_s = x1_q; yb_s = y1_q;
      end
      2'd1: begin
        xa_s = x1_q; ya_s = y1_q; xb_s = x2_q; yb_s = y2_q;
      end
      2'd2: begin
        xa_s = x2_q; ya_s = y2_q; xb_s = x0_q; yb_s = y0_q;
      end
      default: begin
        xa_s = x0_q; ya_s = y0_q; xb_s = x1_q; yb_s = y1_q;
      end
    endcase
  end

  // Edge setup terms and one Bresenham step; e2 gets an extra bit since 2*err can exceed SW
  always_comb begin
    ddx_s     = $signed({2'b00, xb_s}) - $signed({2'b00, xa_s});
    ddy_s     = $signed({2'b00, yb_s}) - $signed({2'b00, ya_s});
    adx_s     = ddx_s[SW-1] ? -ddx_s : ddx_s;
    ndy_s     = ddy_s[SW-1] ? ddy_s : -ddy_s;
    e2_s      = {err_q, 1'b0};
    dx_ext_s  = {dx_q[SW-1], dx_q};
    dy_ext_s  = {dy_q[SW-1], dy_q};
    step_x_s  = (e2_s >= dy_ext_s);
    step_y_s  = (e2_s <= dx_ext_s);
    err_nxt_s = err_q + (step_x_s ? dy_q : {SW{1'b0}}) + (step_y_s ? dx_q : {SW{1'b0}});
    x_nxt_s   = step_x_s ? (sx_neg_q ? x_q - C_ONE : x_q + C_ONE) : x_q;
    y_nxt_s   = step_y_s ? (sy_neg_q ? y_q - C_ONE : y_q + C_ONE) : y_q;
`ifdef SKIP_SHARED_VERTEX_EN
    zero_len_s  = (xa_s == xb_s) && (ya_s == yb_s);
    all_same_s  = (x0_q == x1_q) && (x1_q == x2_q) && (y0_q == y1_q) && (y1_q == y2_q);
    edge_last_s = ((x_q == xb_s) && (y_q == yb_s)) ||
                  ((x_nxt_s == xb_s) && (y_nxt_s == yb_s));
`else
    edge_last_s = (x_q == xb_s) && (y_q == yb_s);
`endif
  end

  // Control FSM with vertex latch, Bresenham state and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      x0_q     <= {COORD_W{1'b0}};
      y0_q     <= {COORD_W{1'b0}};
      x1_q     <= {COORD_W{1'b0}};
      y1_q     <= {COORD_W{1'b0}};
      x2_q     <= {COORD_W{1'b0}};
      y2_q     <= {COORD_W{1'b0}};
      x_q      <= {COORD_W{1'b0}};
      y_q      <= {COORD_W{1'b0}};
      edge_q   <= 2'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      dx_q     <= {SW{1'b0}};
      dy_q     <= {SW{1'b0}};
      err_q    <= {SW{1'b0}};
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else if (bus_if.abort) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          finish_q <= 1'b0;
          if (bus_if.start) begin
            x0_q    <= bus_if.X_0;
            y0_q    <= bus_if.Y_0;
            x1_q    <= bus_if.X_1;
            y1_q    <= bus_if.Y_1;
            x2_q    <= bus_if.X_2;
            y2_q    <= bus_if.Y_2;
            edge_q  <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          x_q      <= xa_s;
          y_q      <= ya_s;
          dx_q     <= adx_s;
          dy_q     <= ndy_s;
          err_q    <= adx_s + ndy_s;
          sx_neg_q <= ddx_s[SW-1];
          sy_neg_q <= ddy_s[SW-1];
`ifdef SKIP_SHARED_VERTEX_EN
          // A fully collapsed triangle still shows V0 once on edge 0
          if (zero_len_s && !((edge_q == 2'd0) && all_same_s)) begin
            if (edge_q == 2'd2) begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              edge_q <= edge_q + 2'd1;
            end
          end else begin
            valid_q <= 1'b1;
            state_q <= S_RUN;
          end
`else
          valid_q <= 1'b1;
          state_q <= S_RUN;
`endif
        end
        S_RUN: begin
          if (bus_if.pix_ready) begin
            if (edge_last_s) begin
              valid_q <= 1'b0;
              if (edge_q == 2'd2) begin
                state_q  <= S_DONE;
                finish_q <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                edge_q  <= edge_q + 2'd1;
                state_q <= S_SETUP;
              end
            end else begin
              x_q   <= x_nxt_s;
              y_q   <= y_nxt_s;
              err_q <= err_nxt_s;
            end
          end
        end
        S_DONE: begin
          finish_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          finish_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.X_Out     = x_q;
  assign bus_if.Y_Out     = y_q;
  assign bus_if.edge_idx  = edge_q;
  assign bus_if.pix_valid = valid_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.finish    = finish_q;
endmodule

// File: tb/tb_draw_triangle_stream.sv
// Scoreboard bench for draw_triangle_stream: directed triangles push expected pixels,
// a negedge monitor pops and compares on every accepted pixel.
module tb_draw_triangle_stream;
  localparam int CW = 12;
`ifdef SKIP_SHARED_VERTEX_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  typedef struct {
    int x;
    int y;
    int e;
    bit exact;
  } pix_t;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  pix_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   finish_cnt = 0;

  always #5 ACLK = ~ACLK;

  draw_triangle_stream_if #(.COORD_W(CW)) bus ();

  draw_triangle_stream #(.COORD_W(CW)) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus_if (bus)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int x, input int y, input int e, input bit exact = 1'b1);
    pix_t p;
    p.x = x; p.y = y; p.e = e; p.exact = exact;
    exp_q.push_back(p);
  endtask

  // Monitor: compare accepted pixels, stall stability and finish placement
  initial begin : monitor
    pix_t p;
    int   px, py, sx, sy, se, ax, ay;
    bit   stall, prev_hs, ok;
    px = 0; py = 0; sx = 0; sy = 0; se = 0; stall = 1'b0; prev_hs = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        stall   = 1'b0;
        prev_hs = 1'b0;
      end else begin
        ax = int'(bus.X_Out);
        ay = int'(bus.Y_Out);
        if (stall && bus.pix_valid) begin
          chk("stall_x_stable", ax, sx);
          chk("stall_y_stable", ay, sy);
          chk("stall_edge_stable", int'(bus.edge_idx), se);
        end
        if (bus.finish) begin
          finish_cnt++;
          chk("finish_all_delivered", exp_q.size(), 0);
`ifndef SKIP_SHARED_VERTEX_EN
          chk("finish_after_last_accept", int'(prev_hs), 1);
`endif
        end
        prev_hs = bus.pix_valid && bus.pix_ready;
        if (prev_hs) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) edge %0d, expected none", ax, ay, bus.edge_idx);
          end else begin
            p = exp_q.pop_front();
            chk("pix_edge", int'(bus.edge_idx), p.e);
            if (p.exact) begin
              chk("pix_x", ax, p.x);
              chk("pix_y", ay, p.y);
            end else begin
              ok = (ax - px <= 1) && (px - ax <= 1) && (ay - py <= 1) && (py - ay <= 1) &&
                   ((ax != px) || (ay != py));
              chk("pix_unit_step", int'(ok), 1);
            end
          end
          px = ax;
          py = ay;
        end
        stall = bus.pix_valid && !bus.pix_ready;
        sx = ax;
        sy = ay;
        se = int'(bus.edge_idx);
      end
    end
  end

  task automatic start_draw(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
    @(posedge ACLK); #1;
    bus.X_0 = CW'(x0); bus.Y_0 = CW'(y0);
    bus.X_1 = CW'(x1); bus.Y_1 = CW'(y1);
    bus.X_2 = CW'(x2); bus.Y_2 = CW'(y2);
    bus.start = 1'b1;
    @(posedge ACLK); #1;
    bus.start = 1'b0;
    bus.X_0 = 12'hAAA; bus.Y_0 = 12'h555; bus.X_1 = 12'h0F0;
    bus.Y_1 = 12'hF0F; bus.X_2 = 12'h333; bus.Y_2 = 12'hCCC;
    @(negedge ACLK);
    chk("setup_busy", int'(bus.busy), 1);
    chk("setup_no_valid", int'(bus.pix_valid), 0);
    @(negedge ACLK);
    chk("first_pixel_latency", int'(bus.pix_valid), 1);
  endtask

  task automatic run_draw(input int pat, input int budget);
    int cnt;
    bit done;
    cnt = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge ACLK); #1;
      bus.pix_ready = (pat == 0) ? 1'b1 : (cnt % 3 == 0);
      @(negedge ACLK);
      if (bus.finish) begin
        done = 1'b1;
      end else begin
        cnt++;
        if (cnt > budget) begin
          n_checks++;
          n_fail++;
          $display("FAIL finish_timeout: got no finish in %0d cycles, expected finish", budget);
          done = 1'b1;
        end
      end
    end
    chk("finish_busy_low", int'(bus.busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge ACLK);
    chk("finish_one_cycle", int'(bus.finish), 0);
    bus.pix_ready = 1'b1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int fc;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b1;
    bus.X_0 = '0; bus.Y_0 = '0; bus.X_1 = '0; bus.Y_1 = '0; bus.X_2 = '0; bus.Y_2 = '0;
    #12;
    chk("rst_x", int'(bus.X_Out), 0);
    chk("rst_y", int'(bus.Y_Out), 0);
    chk("rst_edge", int'(bus.edge_idx), 0);
    chk("rst_valid", int'(bus.pix_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_finish", int'(bus.finish), 0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // T1: right triangle, full throughput
    for (int k = 0; k <= 5 - SKIP; k++) push(k, k, 0);
    for (int k = 0; k <= 5 - SKIP; k++) push(5, 5 - k, 1);
    for (int k = 0; k <= 5 - SKIP; k++) push(5 - k, 0, 2);
    start_draw(0, 0, 5, 5, 5, 0);
    run_draw(0, 200);

    // T2: same triangle, ready pattern 1,0,0
    for (int k = 0; k <= 5 - SKIP; k++) push(k, k, 0);
    for (int k = 0; k <= 5 - SKIP; k++) push(5, 5 - k, 1);
    for (int k = 0; k <= 5 - SKIP; k++) push(5 - k, 0, 2);
    start_draw(0, 0, 5, 5, 5, 0);
    run_draw(1, 400);

    // T5: abort after the 4th accepted pixel, then a fresh draw
    for (int k = 0; k < 4; k++) push(k, k, 0);
    bus.pix_ready = 1'b1;
    start_draw(0, 0, 5, 5, 5, 0);
    n = 1;
    fc = 0;
    while (n < 4 && fc < 50) begin
      @(negedge ACLK);
      if (bus.pix_valid && bus.pix_ready) n++;
      fc++;
    end
    chk("abort_reached_4th", n, 4);
    @(posedge ACLK); #1;
    bus.abort = 1'b1;
    bus.pix_ready = 1'b0;
    @(posedge ACLK); #1;
    bus.abort = 1'b0;
    bus.pix_ready = 1'b1;
    @(negedge ACLK);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.pix_valid), 0);
    fc = finish_cnt;
    repeat (3) @(negedge ACLK);
    chk("abort_no_finish", finish_cnt, fc);
    chk("abort_queue_drained", exp_q.size(), 0);
    for (int k = 0; k <= 2 - SKIP; k++) push(1 + k, 2, 0);
    for (int k = 0; k <= 2 - SKIP; k++) push(3 - k, 2, 1);
    for (int k = 0; k <= 0 - SKIP; k++) push(1, 2, 2);
    start_draw(1, 2, 3, 2, 1, 2);
    run_draw(0, 100);

    // T3: full-range 12-bit triangle
    for (int k = 0; k <= 4095 - SKIP; k++) push(k, (k >= 2048) ? 1 : 0, 0);
    push(4095, 1, 1);
    for (int k = 0; k < 4094; k++) push(0, 0, 1, 1'b0);
    for (int k = 0; k < 1 - SKIP; k++) push(0, 4095, 1);
    for (int k = 0; k <= 4095 - SKIP; k++) push(0, 4095 - k, 2);
    start_draw(0, 0, 4095, 1, 0, 4095);
    run_draw(0, 20000);

    // T6: async reset while stalled in RUN
    bus.pix_ready = 1'b0;
    start_draw(3, 4, 6, 4, 3, 4);
    @(negedge ACLK);
    chk("stalled_x", int'(bus.X_Out), 3);
    chk("stalled_y", int'(bus.Y_Out), 4);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("async_rst_x", int'(bus.X_Out), 0);
    chk("async_rst_y", int'(bus.Y_Out), 0);
    chk("async_rst_edge", int'(bus.edge_idx), 0);
    chk("async_rst_valid", int'(bus.pix_valid), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    bus.pix_ready = 1'b1;

    // T4 after reset: all vertices coincide; a start while busy must be ignored
    for (int e = 0; e <= 2 - 2 * SKIP; e++) push(7, 7, e);
    start_draw(7, 7, 7, 7, 7, 7);
    @(posedge ACLK); #1;
    bus.X_0 = 12'd1; bus.Y_0 = 12'd1; bus.X_1 = 12'd9;
    bus.Y_1 = 12'd9; bus.X_2 = 12'd2; bus.Y_2 = 12'd5;
    bus.start = 1'b1;
    @(posedge ACLK); #1;
    bus.start = 1'b0;
    run_draw(0, 100);
    repeat (10) @(negedge ACLK);
    chk("ignored_start_idle", int'(bus.busy), 0);
    chk("ignored_start_no_pixels", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
